// File: rtl/cin_sync_pkg.sv
// Shared types and width helpers for the cin auto-align block.
package cin_sync_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HUNT   = 3'd1,
    ST_SLIP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } cin_state_e;

  localparam int unsigned BITERR_W = 16;

  // Slip counter must hold the value DIN_W (all positions exhausted).
  function automatic int unsigned slip_cnt_w(input int unsigned din_w);
    return $clog2(din_w) + 1;
  endfunction

endpackage

// File: rtl/cin_slip_shift.sv
// Bit-slip register: re-times each valid input beat by one cycle and delays
// the serial bit stream by a programmable 0..DIN_W-1 bit offset.
module cin_slip_shift #(
  parameter int unsigned DIN_W = 4
) (
  input  logic             aclk_i,
  input  logic             aclk_rst_i,
  input  logic [DIN_W-1:0] cin_i,
  input  logic             cin_valid_i,
  input  logic             slip_i,
  input  logic             clr_i,
  output logic [DIN_W-1:0] beat_o,
  output logic             beat_valid_o
);

  localparam int unsigned OFF_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;
  localparam int unsigned SH_W  = OFF_W + 1;

  logic [OFF_W-1:0] off_q;
  logic [DIN_W-1:0] prev_q;
  logic [DIN_W-1:0] sel_beat;
  logic [SH_W-1:0]  prev_sh;

  // Offset k takes the low DIN_W-k bits of the current beat above the top k
  // bits of the previous beat; offset 0 shifts prev_q out entirely.
  always_comb begin
    prev_sh  = SH_W'(DIN_W) - SH_W'(off_q);
    sel_beat = (cin_i << off_q) | (prev_q >> prev_sh);
  end

  // Beat pipeline and slip offset register.
  always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
    if (aclk_rst_i) begin
      off_q        <= '0;
      prev_q       <= '0;
      beat_o       <= '0;
      beat_valid_o <= 1'b0;
    end else begin
      beat_valid_o <= cin_valid_i;
      if (cin_valid_i) begin
        prev_q <= cin_i;
        beat_o <= sel_beat;
      end
      if (clr_i) begin
        off_q <= '0;
      end else if (slip_i) begin
        off_q <= (off_q == OFF_W'(DIN_W - 1)) ? '0 : off_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cin_autoalign_sync.sv
// Automatic word aligner: hunts for TRAIN_SEQUENCE in the beat stream,
// slipping one bit at a time until found, then emits aligned words.
// Optional pre-lock pattern-error counter: define CIN_BITERR_CNT_EN.
module cin_autoalign_sync
  import cin_sync_pkg::*;
#(
  parameter int unsigned        DIN_W          = 4,
  parameter int unsigned        WORD_W         = 32,
  parameter logic [WORD_W-1:0]  TRAIN_SEQUENCE = 32'hA55A6996,
  parameter int unsigned        HUNT_WORDS     = 16,
  parameter int unsigned        SETTLE_CYC     = 8
) (
  input  logic                          aclk_i,
  input  logic                          aclk_rst_i,
  input  logic [DIN_W-1:0]              cin_i,
  input  logic                          cin_valid_i,
  input  logic                          align_start_i,
  input  logic                          lock_rst_i,
  input  logic                          capture_i,
  output logic                          locked_o,
  output logic                          fail_o,
  output logic [slip_cnt_w(DIN_W)-1:0]  slip_count_o,
  output logic [WORD_W-1:0]             parallel_o,
  output logic                          parallel_valid_o,
  output logic [BITERR_W-1:0]           biterr_count_o
);

  localparam int unsigned BEATS      = WORD_W / DIN_W;
  localparam int unsigned HIST_W     = WORD_W - DIN_W;
  localparam int unsigned HUNT_LIMIT = HUNT_WORDS * BEATS;
  localparam int unsigned HUNT_W     = $clog2(HUNT_LIMIT + 1);
  localparam int unsigned SETTLE_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SLIP_W     = slip_cnt_w(DIN_W);

  cin_state_e state_q, state_d;

  logic [DIN_W-1:0]    ss_beat;
  logic                ss_valid;
  logic [HIST_W-1:0]   hist_q;
  logic [WORD_W-1:0]   window;
  logic                match;
  logic                word_evt;

  logic [HUNT_W-1:0]   hunt_cnt_q;
  logic [SETTLE_W-1:0] settle_cnt_q;
  logic [BEAT_W-1:0]   beat_cnt_q;

  logic                start_hunt;
  logic                slip;
  logic                hunt_clr;
  logic                match_hit;

  cin_slip_shift #(
    .DIN_W (DIN_W)
  ) u_slip (
    .aclk_i       (aclk_i),
    .aclk_rst_i   (aclk_rst_i),
    .cin_i        (cin_i),
    .cin_valid_i  (cin_valid_i),
    .slip_i       (slip),
    .clr_i        (start_hunt),
    .beat_o       (ss_beat),
    .beat_valid_o (ss_valid)
  );

  assign window   = {ss_beat, hist_q};
  assign match    = ss_valid && (window == TRAIN_SEQUENCE);
  assign word_evt = (state_q == ST_LOCKED) && ss_valid && !lock_rst_i &&
                    (beat_cnt_q == BEAT_W'(BEATS - 1));
  assign locked_o = (state_q == ST_LOCKED);
  assign fail_o   = (state_q == ST_FAIL);

  // State register.
  always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
    if (aclk_rst_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; lock reset beats a start request, which beats the FSM.
  always_comb begin
    state_d    = state_q;
    start_hunt = 1'b0;
    slip       = 1'b0;
    hunt_clr   = 1'b0;
    match_hit  = 1'b0;
    if (lock_rst_i) begin
      state_d = ST_IDLE;
    end else if (align_start_i && (state_q != ST_LOCKED)) begin
      state_d    = ST_HUNT;
      start_hunt = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_HUNT: begin
          if (match) begin
            state_d   = ST_LOCKED;
            match_hit = 1'b1;
          end else if (ss_valid && (hunt_cnt_q == HUNT_W'(HUNT_LIMIT - 1))) begin
            state_d = (slip_count_o == SLIP_W'(DIN_W)) ? ST_FAIL : ST_SLIP;
          end
        end
        ST_SLIP: begin
          slip    = 1'b1;
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_W'(SETTLE_CYC - 1)) begin
            state_d  = ST_HUNT;
            hunt_clr = 1'b1;
          end
        end
        ST_LOCKED: state_d = ST_LOCKED;
        ST_FAIL:   state_d = ST_FAIL;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Beat history, alignment counters and word output register.
  always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
    if (aclk_rst_i) begin
      hist_q           <= '0;
      hunt_cnt_q       <= '0;
      settle_cnt_q     <= '0;
      beat_cnt_q       <= '0;
      slip_count_o     <= '0;
      parallel_o       <= '0;
      parallel_valid_o <= 1'b0;
    end else begin
      if (ss_valid) hist_q <= window[WORD_W-1:DIN_W];

      if (start_hunt || hunt_clr)
        hunt_cnt_q <= '0;
      else if ((state_q == ST_HUNT) && ss_valid)
        hunt_cnt_q <= hunt_cnt_q + 1'b1;

      settle_cnt_q <= ((state_q == ST_SETTLE) && (state_d == ST_SETTLE)) ?
                      settle_cnt_q + 1'b1 : '0;

      if (lock_rst_i || start_hunt)
        slip_count_o <= '0;
      else if (slip)
        slip_count_o <= slip_count_o + 1'b1;

      if (match_hit || start_hunt || lock_rst_i)
        beat_cnt_q <= '0;
      else if ((state_q == ST_LOCKED) && ss_valid)
        beat_cnt_q <= (beat_cnt_q == BEAT_W'(BEATS - 1)) ? '0 : beat_cnt_q + 1'b1;

      parallel_valid_o <= word_evt;
      if (word_evt || capture_i) parallel_o <= window;
    end
  end

`ifdef CIN_BITERR_CNT_EN
  logic [DIN_W-1:0]    old_q;
  logic [BITERR_W-1:0] biterr_q;

  // old_q holds the beat that just aged out of the history, i.e. the beat
  // BEATS positions before the newest one.
  always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
    if (aclk_rst_i) begin
      old_q    <= '0;
      biterr_q <= '0;
    end else begin
      if (ss_valid) old_q <= hist_q[DIN_W-1:0];
      if (lock_rst_i || start_hunt)
        biterr_q <= '0;
      else if ((state_q != ST_LOCKED) && ss_valid && (ss_beat != old_q) && (biterr_q != '1))
        biterr_q <= biterr_q + 1'b1;
    end
  end

  assign biterr_count_o = biterr_q;
`else
  assign biterr_count_o = '0;
`endif

endmodule

// File: tb/tb_cin_autoalign_sync.sv
// Directed bench for cin_autoalign_sync (DIN_W=4, WORD_W=32, HUNT_WORDS=4).
module tb_cin_autoalign_sync;

  logic        aclk_i;
  logic        aclk_rst_i;
  logic [3:0]  cin_i;
  logic        cin_valid_i;
  logic        align_start_i;
  logic        lock_rst_i;
  logic        capture_i;
  logic        locked_o;
  logic        fail_o;
  logic [2:0]  slip_count_o;
  logic [31:0] parallel_o;
  logic        parallel_valid_o;
  logic [15:0] biterr_count_o;

  cin_autoalign_sync #(
    .DIN_W          (4),
    .WORD_W         (32),
    .TRAIN_SEQUENCE (32'hA55A6996),
    .HUNT_WORDS     (4),
    .SETTLE_CYC     (8)
  ) dut (
    .aclk_i           (aclk_i),
    .aclk_rst_i       (aclk_rst_i),
    .cin_i            (cin_i),
    .cin_valid_i      (cin_valid_i),
    .align_start_i    (align_start_i),
    .lock_rst_i       (lock_rst_i),
    .capture_i        (capture_i),
    .locked_o         (locked_o),
    .fail_o           (fail_o),
    .slip_count_o     (slip_count_o),
    .parallel_o       (parallel_o),
    .parallel_valid_o (parallel_valid_o),
    .biterr_count_o   (biterr_count_o)
  );

  initial aclk_i = 1'b0;
  always #5 aclk_i = ~aclk_i;

  int          checks;
  int          failures;
  int          mode;        // 0 zeros, 1 training, 2 training rotated 2 bits, 3 sparse ones
  bit          stream_on;
  bit          toggle;
  int unsigned n_beat;
  logic [31:0] tr;
  logic [31:0] rot2;
  int          lat;
  bit          got;

  function automatic logic [3:0] beat_of(input int unsigned n);
    logic [31:0] w;
    w = '0;
    if (mode == 1) w = tr;
    if (mode == 2) w = rot2;
    if (mode == 3) return ((n % 16) == 0) ? 4'h1 : 4'h0;
    return w[4*(n%8) +: 4];
  endfunction

  // Present the next stream beat, then advance one clock and settle.
  task tick();
    if (stream_on) begin
      cin_valid_i = toggle ? ~cin_valid_i : 1'b1;
      if (cin_valid_i) begin
        cin_i  = beat_of(n_beat);
        n_beat = n_beat + 1;
      end
    end else begin
      cin_valid_i = 1'b0;
    end
    @(posedge aclk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task pulse_align();
    align_start_i = 1'b1;
    tick();
    align_start_i = 1'b0;
  endtask

  task pulse_lock_rst();
    lock_rst_i = 1'b1;
    tick();
    lock_rst_i = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    tr   = 32'hA55A6996;
    rot2 = {tr[1:0], tr[31:2]};
    mode = 0; stream_on = 1'b0; toggle = 1'b0; n_beat = 0;
    aclk_rst_i = 1'b1; cin_i = '0; cin_valid_i = 1'b0;
    align_start_i = 1'b0; lock_rst_i = 1'b0; capture_i = 1'b0;

    // Reset state
    repeat (3) tick();
    aclk_rst_i = 1'b0;
    tick();
    chk("rst_locked", locked_o, 0);
    chk("rst_fail", fail_o, 0);
    chk("rst_slip", slip_count_o, 0);
    chk("rst_parallel", parallel_o, 0);
    chk("rst_biterr", biterr_count_o, 0);

    // Capture in IDLE: window on the 9th tick holds beats 0..7 = training word
    mode = 1; stream_on = 1'b1; n_beat = 0;
    for (int i = 0; i <= 8; i++) begin
      capture_i = (i == 8);
      tick();
    end
    capture_i = 1'b0;
    chk("capture_data", parallel_o, 32'hA55A6996);
    chk("capture_no_strobe", parallel_valid_o, 0);
    chk("capture_not_locked", locked_o, 0);

    // Aligned stream: match at post-slip beat 15, i.e. 3 ticks after start
    repeat (4) tick();
    pulse_align();
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (locked_o) begin lat = k; break; end
    end
    chk("lock_latency", lat, 3);
    chk("lock_slips", slip_count_o, 0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (parallel_valid_o) begin lat = k; break; end
    end
    chk("first_word_latency", lat, 8);
    chk("first_word_data", parallel_o, 32'hA55A6996);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (parallel_valid_o) begin lat = k; break; end
    end
    chk("word_period", lat, 8);
    chk("word_data", parallel_o, 32'hA55A6996);
    tick();
    chk("strobe_one_cycle", parallel_valid_o, 0);

    // Start request while locked has no effect
    pulse_align();
    chk("start_ignored_locked", locked_o, 1);
    chk("start_ignored_slips", slip_count_o, 0);

    // Half-rate valid while locked
    toggle = 1'b1;
    repeat (20) tick();
    got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (parallel_valid_o) begin got = 1'b1; break; end
    end
    chk("toggle_strobe_seen", got, 1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (parallel_valid_o) begin lat = k; break; end
    end
    chk("toggle_word_period", lat, 16);
    chk("toggle_word_data", parallel_o, 32'hA55A6996);
    toggle = 1'b0;

    // Lock reset
    pulse_lock_rst();
    chk("lockrst_locked", locked_o, 0);
    chk("lockrst_fail", fail_o, 0);
    chk("lockrst_slips", slip_count_o, 0);

    // Stream rotated by 2 bits needs exactly two slips
    mode = 2;
    repeat (10) tick();
    pulse_align();
    got = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (locked_o) begin got = 1'b1; break; end
    end
    chk("rot2_locked", got, 1);
    chk("rot2_slips", slip_count_o, 2);
    got = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (parallel_valid_o) begin got = 1'b1; break; end
    end
    chk("rot2_word_seen", got, 1);
    chk("rot2_word_data", parallel_o, 32'hA55A6996);
    pulse_lock_rst();

    // All-zero stream exhausts every slip position
    mode = 0;
    repeat (10) tick();
    pulse_align();
    got = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (fail_o) begin got = 1'b1; break; end
    end
    chk("zero_fail", got, 1);
    chk("zero_not_locked", locked_o, 0);
    chk("zero_slips", slip_count_o, 4);
    repeat (5) tick();
    chk("fail_holds", fail_o, 1);
    pulse_align();
    chk("restart_fail_clr", fail_o, 0);
    chk("restart_slips_clr", slip_count_o, 0);
    pulse_lock_rst();

    // Sparse ones pre-lock: diffs vs 8 beats earlier at beats 0, 8 and 16
    stream_on = 1'b0;
    aclk_rst_i = 1'b1;
    tick();
    aclk_rst_i = 1'b0;
    tick();
    pulse_align();
    mode = 3; n_beat = 0; stream_on = 1'b1;
    for (int i = 0; i < 24; i++) begin
      capture_i = (i == 17);
      tick();
    end
    capture_i = 1'b0;
    stream_on = 1'b0;
    repeat (2) tick();
    chk("sparse_capture", parallel_o, 32'h1000_0000);
`ifdef CIN_BITERR_CNT_EN
    chk("biterr_count", biterr_count_o, 3);
`else
    chk("biterr_count", biterr_count_o, 0);
`endif
    chk("sparse_slips", slip_count_o, 0);

    // Asynchronous reset mid-hunt clears outputs without a clock edge
    #2;
    aclk_rst_i = 1'b1;
    #1;
    chk("arst_parallel", parallel_o, 0);
    chk("arst_biterr", biterr_count_o, 0);
    chk("arst_locked", locked_o, 0);
    chk("arst_fail", fail_o, 0);
    chk("arst_slips", slip_count_o, 0);
    chk("arst_strobe", parallel_valid_o, 0);
    tick();
    aclk_rst_i = 1'b0;

    // After reset no alignment happens without a new start request
    mode = 1; stream_on = 1'b1;
    repeat (30) tick();
    chk("no_auto_restart", locked_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
